// File: rtl/handshake_pulse_feeder.sv
// handshake_pulse_feeder
// Source-side initiator for a handshake pulse synchronizer, clk_fast domain.
// Bursty single-cycle event requests are counted as pending. One-cycle pulses
// are issued to the synchronizer only while it reports not busy.
//
// Optional build macro: HSF_DROP_CNT_EN
//   defined   -> adds drop_cnt[7:0], a saturating count of dropped events
//   undefined -> no drop_cnt port; the sticky overflow flag alone reports loss
//
// Handshake: event_in is a fire-and-forget request. Every high cycle is one
// event. It is accepted when the pending counter has room, or when an issue
// frees a slot on the same edge. pulse_out is a one-cycle strobe. It is raised
// only from IDLE with synchro_busy low, and it is never raised again until the
// synchronizer has gone busy and returned idle, or until the arm window ends
// without busy being seen.

module handshake_pulse_feeder #(
  parameter int CNT_W    = 4,
  parameter int ARM_WAIT = 3
) (
  input  logic             clk_fast,
  input  logic             reset,
  input  logic             event_in,
  input  logic             synchro_busy,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             full,
  output logic             overflow,
`ifdef HSF_DROP_CNT_EN
  output logic [7:0]       drop_cnt,
`endif
  output logic             idle
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       ARM_LOAD = 4'(ARM_WAIT);

  state_t           state_q, state_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [3:0]       timer_q, timer_d;

  logic             issue;
  logic             accept;
  logic             drop;

`ifdef HSF_DROP_CNT_EN
  logic [7:0]       drop_q, drop_d;
`endif

  // Event acceptance: an issue on the same edge frees a slot, so a full
  // counter still accepts an event when it is issuing on that edge.
  always_comb begin
    issue  = (state_q == ST_IDLE) && (cnt_q != '0) && !synchro_busy;
    accept = event_in && ((cnt_q != CNT_MAX) || issue);
    drop   = event_in && !accept;
  end

  // Next-state logic for the FSM, the pending counter and the loss reporting.
  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | drop;

    // Net count change; the counter saturates because a full counter drops events.
    case ({accept, issue})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d = ST_ISSUE;
          pulse_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_ARM;
        timer_d = ARM_LOAD;
      end
      ST_ARM: begin
        if (synchro_busy) begin
          state_d = ST_BUSY;
          timer_d = 4'd0;
        end else begin
          // The window ends when the timer counts down to zero without busy.
          timer_d = timer_q - 4'd1;
          if (timer_q <= 4'd1) begin
            state_d = ST_IDLE;
            timer_d = 4'd0;
          end
        end
      end
      ST_BUSY: begin
        if (!synchro_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = 4'd0;
      end
    endcase
  end

`ifdef HSF_DROP_CNT_EN
  // Dropped-event count. It saturates at 255 and still counts while overflow is already set.
  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Register for the dropped-event count.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

  // State and registered outputs. Reset discards all pending events.
  always_ff @(posedge clk_fast) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      timer_q <= 4'd0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      timer_q <= timer_d;
    end
  end

  assign pulse_out   = pulse_q;
  assign pending_cnt = cnt_q;
  assign overflow    = ovf_q;
  assign full        = (cnt_q == CNT_MAX);
  assign idle        = (state_q == ST_IDLE) && (cnt_q == '0);

endmodule
